// File: rtl/debug_pkg.sv
// Shared encodings for the run/halt/step sequencer.
// FSM states and the reasons the core last halted.
package debug_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_RESET = 2'd0;
    localparam logic [1:0] CAUSE_CMD   = 2'd1;
    localparam logic [1:0] CAUSE_BP    = 2'd2;
    localparam logic [1:0] CAUSE_STOP  = 2'd3;

endpackage

// File: rtl/debug_run_ctrl_bp_match.sv
// PC breakpoint comparator.
// A skip flag masks the hit so execution can resume from the breakpoint PC.
module bp_match
    import debug_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
    input  logic        bp_skip,
    output logic        bp_hit
);

    // Hit only when armed, matching, and not resuming from this address.
    always_comb begin
        bp_hit = bp_valid & (pc == bp_addr) & ~bp_skip;
    end

endmodule

// File: rtl/debug_run_ctrl.sv
// Run/halt/step sequencer: core clock-enable, cycle counter, debug grant.
// Breakpoint logic is present only when DEBUG_BP_EN is defined.
module debug_run_ctrl
    import debug_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_halt,
    input  logic [STEP_W-1:0] step_n,
    input  logic [31:0]       pc,
    input  logic              stop,
    input  logic [31:0]       bp_addr,
    input  logic              bp_valid,
    input  logic              dbg_req,
    input  logic              clr_cnt,
    output logic              cpu_ce,
    output logic              dbg_ack,
    output logic              halted,
    output logic [1:0]        state,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_cnt
);

    state_e            st;
    logic [STEP_W-1:0] step_left;
    logic [STEP_W-1:0] step_load;
    logic              running;
    logic              leave_halt;
    logic              bp_hit;

    assign running    = (st == RUN) || (st == STEP);
    assign step_load  = (step_n == '0) ? STEP_W'(1) : step_n;
    assign leave_halt = (st == HALT) && !dbg_req && !cmd_halt
                        && (cmd_step || cmd_run);

`ifdef DEBUG_BP_EN
    logic bp_skip;

    bp_match u_bp_match (
        .pc       (pc),
        .bp_addr  (bp_addr),
        .bp_valid (bp_valid),
        .bp_skip  (bp_skip),
        .bp_hit   (bp_hit)
    );

    // Arm the skip when resuming at the breakpoint PC; drop it once the core moves.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bp_skip <= 1'b0;
        end else if (leave_halt) begin
            bp_skip <= (pc == bp_addr);
        end else if (cpu_ce) begin
            bp_skip <= 1'b0;
        end
    end
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
`endif

    // Combinational so the core never steps past a breakpoint or stop.
    assign cpu_ce     = running && !bp_hit && !stop;
    assign halted     = (st == HALT);
    assign state      = st;

    // Sequencer FSM: stop > breakpoint > halt > step > run > step done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st         <= HALT;
            halt_cause <= CAUSE_RESET;
            step_left  <= '0;
        end else begin
            unique case (st)
                HALT: begin
                    if (!dbg_req && !cmd_halt) begin
                        if (cmd_step) begin
                            st        <= STEP;
                            step_left <= step_load;
                        end else if (cmd_run) begin
                            st <= RUN;
                        end
                    end
                end
                RUN, STEP: begin
                    if (stop) begin
                        st         <= HALT;
                        halt_cause <= CAUSE_STOP;
                        step_left  <= '0;
                    end else if (bp_hit) begin
                        st         <= HALT;
                        halt_cause <= CAUSE_BP;
                        step_left  <= '0;
                    end else if (cmd_halt) begin
                        st         <= HALT;
                        halt_cause <= CAUSE_CMD;
                        step_left  <= '0;
                    end else if (cmd_step) begin
                        st        <= STEP;
                        step_left <= step_load;
                    end else if (cmd_run) begin
                        st <= RUN;
                    end else if (st == STEP && cpu_ce) begin
                        if (step_left <= STEP_W'(1)) begin
                            st         <= HALT;
                            halt_cause <= CAUSE_CMD;
                            step_left  <= '0;
                        end else begin
                            step_left <= step_left - STEP_W'(1);
                        end
                    end
                end
                default: begin
                    st <= HALT;
                end
            endcase
        end
    end

    // Saturating count of enabled cycles; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_cnt <= '0;
        end else if (clr_cnt) begin
            cycle_cnt <= '0;
        end else if (cpu_ce && (cycle_cnt != {CNT_W{1'b1}})) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // Grant debug ports only while halted, one cycle behind the request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dbg_ack <= 1'b0;
        end else begin
            dbg_ack <= dbg_req && (st == HALT);
        end
    end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed bench for debug_run_ctrl (CNT_W=4 build).
// Breakpoint expectations follow DEBUG_BP_EN.
module tb_debug_run_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_run, cmd_step, cmd_halt;
    logic [7:0]  step_n;
    logic [31:0] pc;
    logic        stop;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic        dbg_req, clr_cnt;
    logic        cpu_ce, dbg_ack, halted;
    logic [1:0]  state, halt_cause;
    logic [3:0]  cycle_cnt;

    int checks = 0;
    int errors = 0;

    debug_run_ctrl #(.CNT_W(4), .STEP_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_halt   (cmd_halt),
        .step_n     (step_n),
        .pc         (pc),
        .stop       (stop),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .dbg_req    (dbg_req),
        .clr_cnt    (clr_cnt),
        .cpu_ce     (cpu_ce),
        .dbg_ack    (dbg_ack),
        .halted     (halted),
        .state      (state),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Simple core model: PC advances by 4 on every enabled cycle.
    always @(posedge clk) begin
        if (!rstn) pc <= 32'h0;
        else if (cpu_ce) pc <= pc + 32'd4;
    end

    typedef struct {
        logic       run, step, halt;
        logic [7:0] n;
        logic       stp, req, clr;
        logic       ce, hlt;
        logic [1:0] st, cause;
        logic       ack;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        //          run step halt n  stp req clr | ce hlt st cause ack cnt
        tbl[0]  = '{0, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd0, 0, 4'd0};
        tbl[1]  = '{0, 1, 0, 8'd3, 0, 0, 0,  0, 1, 2'd0, 2'd0, 0, 4'd0};
        tbl[2]  = '{0, 0, 0, 8'd0, 0, 0, 0,  1, 0, 2'd2, 2'd0, 0, 4'd0};
        tbl[3]  = '{0, 0, 0, 8'd0, 0, 0, 0,  1, 0, 2'd2, 2'd0, 0, 4'd1};
        tbl[4]  = '{0, 0, 0, 8'd0, 0, 0, 0,  1, 0, 2'd2, 2'd0, 0, 4'd2};
        tbl[5]  = '{0, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd1, 0, 4'd3};
        tbl[6]  = '{0, 1, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd1, 0, 4'd3};
        tbl[7]  = '{0, 0, 0, 8'd0, 0, 0, 0,  1, 0, 2'd2, 2'd1, 0, 4'd3};
        tbl[8]  = '{0, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd1, 0, 4'd4};
        tbl[9]  = '{1, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd1, 0, 4'd4};
        tbl[10] = '{0, 0, 0, 8'd0, 0, 1, 0,  1, 0, 2'd1, 2'd1, 0, 4'd4};
        tbl[11] = '{0, 0, 0, 8'd0, 0, 1, 0,  1, 0, 2'd1, 2'd1, 0, 4'd5};
        tbl[12] = '{0, 0, 1, 8'd0, 0, 1, 0,  1, 0, 2'd1, 2'd1, 0, 4'd6};
        tbl[13] = '{0, 0, 0, 8'd0, 0, 1, 0,  0, 1, 2'd0, 2'd1, 0, 4'd7};
        tbl[14] = '{1, 0, 0, 8'd0, 0, 1, 0,  0, 1, 2'd0, 2'd1, 1, 4'd7};
        tbl[15] = '{0, 0, 0, 8'd0, 0, 1, 0,  0, 1, 2'd0, 2'd1, 1, 4'd7};
        tbl[16] = '{0, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd1, 1, 4'd7};
        tbl[17] = '{0, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd1, 0, 4'd7};
        tbl[18] = '{1, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd1, 0, 4'd7};
        tbl[19] = '{0, 0, 1, 8'd0, 1, 0, 0,  0, 0, 2'd1, 2'd1, 0, 4'd7};
        tbl[20] = '{0, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd3, 0, 4'd7};
        tbl[21] = '{0, 0, 0, 8'd0, 0, 0, 1,  0, 1, 2'd0, 2'd3, 0, 4'd7};
        tbl[22] = '{0, 0, 0, 8'd0, 0, 0, 0,  0, 1, 2'd0, 2'd3, 0, 4'd0};

        rstn = 1'b0;
        cmd_run = 0; cmd_step = 0; cmd_halt = 0; step_n = 8'd0;
        stop = 0; bp_addr = 32'h0; bp_valid = 0; dbg_req = 0; clr_cnt = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Table: inputs applied at negedge, outputs checked 1ns later.
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            cmd_run  = tbl[i].run;
            cmd_step = tbl[i].step;
            cmd_halt = tbl[i].halt;
            step_n   = tbl[i].n;
            stop     = tbl[i].stp;
            dbg_req  = tbl[i].req;
            clr_cnt  = tbl[i].clr;
            #1;
            chk($sformatf("v%0d_ce", i), 32'(cpu_ce), 32'(tbl[i].ce));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].hlt));
            chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("v%0d_cause", i), 32'(halt_cause), 32'(tbl[i].cause));
            chk($sformatf("v%0d_ack", i), 32'(dbg_ack), 32'(tbl[i].ack));
            chk($sformatf("v%0d_cnt", i), 32'(cycle_cnt), 32'(tbl[i].cnt));
        end

        // Long step aborted by halt in its 5th enabled cycle.
        @(negedge clk);
        cmd_step = 1; step_n = 8'd200;
        @(negedge clk);
        cmd_step = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            cmd_halt = (i == 5);
            #1;
            chk($sformatf("abort_ce%0d", i), 32'(cpu_ce), 32'd1);
        end
        @(negedge clk);
        cmd_halt = 0;
        #1;
        chk("abort_halted", 32'(halted), 32'd1);
        chk("abort_cause", 32'(halt_cause), 32'd1);
        chk("abort_cnt", 32'(cycle_cnt), 32'd5);

        // Counter saturation, then clear while enabled.
        @(negedge clk);
        clr_cnt = 1;
        @(negedge clk);
        clr_cnt = 0; cmd_run = 1;
        @(negedge clk);
        cmd_run = 0;
        repeat (20) @(negedge clk);
        #1;
        chk("sat_cnt", 32'(cycle_cnt), 32'd15);
        chk("sat_ce", 32'(cpu_ce), 32'd1);
        clr_cnt = 1;
        @(negedge clk);
        clr_cnt = 0;
        #1;
        chk("clr_cnt", 32'(cycle_cnt), 32'd0);

        // Reset while running.
        @(negedge clk);
        rstn = 0;
        @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_ce", 32'(cpu_ce), 32'd0);
        chk("rst_cnt", 32'(cycle_cnt), 32'd0);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        rstn = 1;
        bp_addr = 32'h10; bp_valid = 1;

        // Breakpoint at 0x10, then resume past it.
        @(negedge clk);
        cmd_run = 1;
        @(negedge clk);
        cmd_run = 0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (pc == 32'h10) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("bp_reach", 32'(found), 32'd1);
`ifdef DEBUG_BP_EN
        chk("bp_ce_drop", 32'(cpu_ce), 32'd0);
        @(negedge clk);
        #1;
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_cause", 32'(halt_cause), 32'd2);
        chk("bp_pc_hold", pc, 32'h10);
        cmd_run = 1;
        @(negedge clk);
        cmd_run = 0;
        #1;
        chk("skip_ce", 32'(cpu_ce), 32'd1);
        chk("skip_state", 32'(state), 32'd1);
        chk("skip_pc", pc, 32'h10);
`else
        chk("nobp_ce", 32'(cpu_ce), 32'd1);
        chk("nobp_state", 32'(state), 32'd1);
`endif
        @(negedge clk);
        #1;
        chk("past_pc", pc, 32'h14);
        chk("past_ce", 32'(cpu_ce), 32'd1);
        cmd_halt = 1;
        @(negedge clk);
        cmd_halt = 0;
        #1;
        chk("final_halted", 32'(halted), 32'd1);
        chk("final_cause", 32'(halt_cause), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
